// File: rtl/packet_pkg.sv
// Shared types and sizing for the packet writer and the routing/display decoder.
package packet_pkg;

    localparam int unsigned NIBBLE_W  = 4;
    localparam int unsigned NIBBLES   = 6;
    localparam int unsigned PACKET_W  = NIBBLE_W * NIBBLES;
    localparam int unsigned NUM_SLOTS = 6;
    localparam int unsigned COUNT_W   = 3;
    localparam int unsigned DEST_W    = 4;

    localparam logic [COUNT_W-1:0] FULL_COUNT = COUNT_W'(NIBBLES);

    typedef logic [PACKET_W-1:0] packet_t;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        FULL,
        WRITE
    } writer_state_e;

endpackage

// File: rtl/packet_nibble_buffer.sv
// Assembly buffer: shifts hex digits in from the right and counts them.
// The first digit typed ends up in the MSB nibble once the packet is full.
module packet_nibble_buffer
    import packet_pkg::*;
(
    input  logic                clock,
    input  logic                clear_n,
    input  logic                load,
    input  logic                shift,
    input  logic                clear,
    input  logic [NIBBLE_W-1:0] nibble,
    output packet_t             data,
    output logic [COUNT_W-1:0]  count,
    output logic                full
);

    assign full = (count == FULL_COUNT);

    // Buffer and digit counter; a shift into a full buffer is dropped.
    always_ff @(posedge clock) begin
        if (!clear_n || clear) begin
            data  <= '0;
            count <= '0;
        end else if (load) begin
            data  <= {{(PACKET_W-NIBBLE_W){1'b0}}, nibble};
            count <= COUNT_W'(1);
        end else if (shift && !full) begin
            data  <= {data[PACKET_W-NIBBLE_W-1:0], nibble};
            count <= count + COUNT_W'(1);
        end
    end

endmodule

// File: rtl/packet_table_writer.sv
// Packet table writer: collects hex digits into a packet and commits it
// into one slot of the packet table, reporting success or a bad slot index.
module packet_table_writer
    import packet_pkg::*;
(
    input  logic                 clock,
    input  logic                 clear_n,
    input  logic [NIBBLE_W-1:0]  nibble_in,
    input  logic                 nibble_strobe,
    input  logic [DEST_W-1:0]    dest,
    input  logic                 commit,
    input  logic                 abort,
    output packet_t              packet_out [NUM_SLOTS],
    output logic [NUM_SLOTS-1:0] slot_valid,
    output packet_t              preview,
    output logic [COUNT_W-1:0]   digit_count,
    output logic                 write_ack,
    output logic                 dest_err
);

    writer_state_e       state_q, state_d;
    logic [DEST_W-1:0]   dest_q;
    logic                buf_load, buf_shift, buf_clear, buf_full;
    logic                latch_dest, dest_ok, do_write;

    packet_nibble_buffer u_buffer (
        .clock   (clock),
        .clear_n (clear_n),
        .load    (buf_load),
        .shift   (buf_shift),
        .clear   (buf_clear),
        .nibble  (nibble_in),
        .data    (preview),
        .count   (digit_count),
        .full    (buf_full)
    );

    assign dest_ok = (dest_q < DEST_W'(NUM_SLOTS));

    // State register.
    always_ff @(posedge clock) begin
        if (!clear_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic; abort beats commit beats strobe.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (!abort && nibble_strobe) state_d = COLLECT;
            end
            COLLECT: begin
                if (abort)       state_d = IDLE;
                else if (commit) state_d = WRITE;
                else if (nibble_strobe && digit_count == FULL_COUNT - COUNT_W'(1))
                    state_d = FULL;
            end
            FULL: begin
                if (abort)       state_d = IDLE;
                else if (commit) state_d = WRITE;
            end
            WRITE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Buffer controls and table write enables decoded from state and inputs.
    always_comb begin
        buf_load   = 1'b0;
        buf_shift  = 1'b0;
        buf_clear  = 1'b0;
        latch_dest = 1'b0;
        do_write   = 1'b0;
        unique case (state_q)
            IDLE:    buf_load = nibble_strobe && !abort;
            COLLECT: begin
                buf_clear  = abort;
                latch_dest = !abort && commit;
                buf_shift  = !abort && !commit && nibble_strobe && !buf_full;
            end
            FULL: begin
                buf_clear  = abort;
                latch_dest = !abort && commit;
            end
            WRITE: begin
                buf_clear = 1'b1;
                do_write  = dest_ok;
            end
            default: ;
        endcase
    end

    // Destination latch, packet table, valid flags and result pulses.
    always_ff @(posedge clock) begin
        if (!clear_n) begin
            dest_q     <= '0;
            slot_valid <= '0;
            write_ack  <= 1'b0;
            dest_err   <= 1'b0;
            for (int unsigned i = 0; i < NUM_SLOTS; i++) packet_out[i] <= '0;
        end else begin
            if (latch_dest) dest_q <= dest;
            write_ack <= do_write;
            dest_err  <= (state_q == WRITE) && !dest_ok;
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                if (do_write && dest_q == DEST_W'(i)) begin
                    packet_out[i] <= preview;
                    slot_valid[i] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_packet_table_writer.sv
// Directed bench for packet_table_writer with hand-computed expectations.
module tb_packet_table_writer;
    import packet_pkg::*;

    logic                 clock = 1'b0;
    logic                 clear_n;
    logic [NIBBLE_W-1:0]  nibble_in;
    logic                 nibble_strobe;
    logic [DEST_W-1:0]    dest;
    logic                 commit;
    logic                 abort;
    packet_t              packet_out [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] slot_valid;
    packet_t              preview;
    logic [COUNT_W-1:0]   digit_count;
    logic                 write_ack;
    logic                 dest_err;

    int n_checks = 0;
    int n_fail   = 0;

    packet_table_writer dut (
        .clock         (clock),
        .clear_n       (clear_n),
        .nibble_in     (nibble_in),
        .nibble_strobe (nibble_strobe),
        .dest          (dest),
        .commit        (commit),
        .abort         (abort),
        .packet_out    (packet_out),
        .slot_valid    (slot_valid),
        .preview       (preview),
        .digit_count   (digit_count),
        .write_ack     (write_ack),
        .dest_err      (dest_err)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input logic [3:0] n);
        nibble_in     = n;
        nibble_strobe = 1'b1;
        step();
        nibble_strobe = 1'b0;
    endtask

    task automatic do_commit(input logic [3:0] d);
        dest   = d;
        commit = 1'b1;
        step();
        commit = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    initial begin
        clear_n = 1'b0; nibble_in = '0; nibble_strobe = 1'b0;
        dest = '0; commit = 1'b0; abort = 1'b0;
        step(); step();

        // Reset state
        chk("rst_preview", preview, 0);
        chk("rst_count", digit_count, 0);
        chk("rst_valid", slot_valid, 0);
        chk("rst_ack", write_ack, 0);
        chk("rst_err", dest_err, 0);
        chk("rst_pkt0", packet_out[0], 0);

        // Reset mid-collect
        clear_n = 1'b1;
        strobe(4'h3); strobe(4'h7);
        chk("pre_rst_preview", preview, 32'h37);
        chk("pre_rst_count", digit_count, 2);
        clear_n = 1'b0; step(); clear_n = 1'b1;
        chk("midrst_preview", preview, 0);
        chk("midrst_count", digit_count, 0);
        strobe(4'h9);
        chk("post_rst_count", digit_count, 1);
        chk("post_rst_preview", preview, 32'h9);
        do_abort();
        chk("abort_count", digit_count, 0);

        // Full packet to slot 2
        for (int i = 1; i <= 6; i++) strobe(4'(i));
        chk("full_preview", preview, 32'h123456);
        chk("full_count", digit_count, 6);
        do_commit(4'd2);
        chk("commit_ack_early", write_ack, 0);
        chk("commit_pkt_early", packet_out[2], 0);
        step();
        chk("w2_pkt", packet_out[2], 32'h123456);
        chk("w2_valid", slot_valid, 32'b000100);
        chk("w2_ack", write_ack, 1);
        chk("w2_err", dest_err, 0);
        chk("w2_preview", preview, 0);
        chk("w2_count", digit_count, 0);
        step();
        chk("w2_ack_drop", write_ack, 0);

        // Partial packet to slot 0
        strobe(4'hA); strobe(4'hB);
        chk("ab_preview", preview, 32'hAB);
        chk("ab_count", digit_count, 2);
        do_commit(4'd0); step();
        chk("w0_pkt", packet_out[0], 32'h0000AB);
        chk("w0_valid", slot_valid, 32'b000101);
        chk("w0_ack", write_ack, 1);

        // Seventh strobe ignored
        strobe(4'hF); strobe(4'hE); strobe(4'hD);
        strobe(4'hC); strobe(4'hB); strobe(4'hA);
        strobe(4'h7);
        chk("ovf_preview", preview, 32'hFEDCBA);
        chk("ovf_count", digit_count, 6);

        // Bad destination
        do_commit(4'd7); step();
        chk("bad_err", dest_err, 1);
        chk("bad_ack", write_ack, 0);
        chk("bad_valid", slot_valid, 32'b000101);
        chk("bad_pkt0", packet_out[0], 32'h0000AB);
        chk("bad_pkt2", packet_out[2], 32'h123456);
        chk("bad_preview", preview, 0);
        step();
        chk("bad_err_drop", dest_err, 0);

        // Abort beats commit and strobe
        strobe(4'h5); strobe(4'h6);
        nibble_in = 4'h9; nibble_strobe = 1'b1; dest = 4'd1;
        commit = 1'b1; abort = 1'b1;
        step();
        nibble_strobe = 1'b0; commit = 1'b0; abort = 1'b0;
        chk("prio_preview", preview, 0);
        chk("prio_count", digit_count, 0);
        step();
        chk("prio_ack", write_ack, 0);
        chk("prio_err", dest_err, 0);
        chk("prio_valid", slot_valid, 32'b000101);
        strobe(4'h8);
        chk("prio_idle_count", digit_count, 1);
        chk("prio_idle_preview", preview, 32'h8);
        do_abort();

        // Overwrite slot 5
        for (int i = 0; i < 6; i++) strobe(4'hF);
        do_commit(4'd5); step();
        chk("w5a_pkt", packet_out[5], 32'hFFFFFF);
        chk("w5a_valid", slot_valid, 32'b100101);
        strobe(4'h1);
        do_commit(4'd5); step();
        chk("w5b_pkt", packet_out[5], 32'h000001);
        chk("w5b_valid", slot_valid, 32'b100101);
        chk("w5b_ack", write_ack, 1);
        chk("w5b_pkt0", packet_out[0], 32'h0000AB);
        chk("w5b_pkt1", packet_out[1], 0);
        chk("w5b_pkt2", packet_out[2], 32'h123456);
        chk("w5b_pkt3", packet_out[3], 0);
        chk("w5b_pkt4", packet_out[4], 0);

        // Commit with empty buffer is ignored
        step();
        do_commit(4'd3);
        step();
        chk("idle_commit_ack", write_ack, 0);
        chk("idle_commit_err", dest_err, 0);
        chk("idle_commit_valid", slot_valid, 32'b100101);
        chk("idle_commit_count", digit_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
